vga_screen_ctrl: RTL
====================

VGA_SCREEN_CTRL -- requirements
Module: vga_screen_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, 3, number of save/load slots (2..8).
REQ-002 Parameter NUM_PADS, 3, number of sensor pads drawn on the GAME screen (1..8).
REQ-003 Parameter H_ACTIVE, 640, active pixels per line.
REQ-004 Parameter V_ACTIVE, 480, active lines per frame.
REQ-005 Parameter HIT_HOLD, 16, frames a pad stays lit after a hit (2..255).
REQ-006 Parameters PAD_X0 155, PAD_PITCH 146, PAD_W 38, PAD_Y0 199, PAD_H 48: pad p box is x in [PAD_X0+p*PAD_PITCH, +PAD_W), y in [PAD_Y0, +PAD_H).
REQ-007 Parameters SLOT_X0 12, SLOT_W 112, SLOT_Y0 287, SLOT_PITCH 32, SLOT_H 28: slot s box is x in [SLOT_X0, +SLOT_W), y in [SLOT_Y0+s*SLOT_PITCH, +SLOT_H).
REQ-008 iVGA_CLK  in  1  pixel clock; all logic on rising edge.
REQ-009 iRST_n  in  1  reset, asynchronous, active-low.
REQ-010 iBLANK_n  in  1  high during active video.
REQ-011 iVS  in  1  vertical sync, active-low.
REQ-012 iBtn  in  4  asynchronous controller levels; bit0 back, bit1 next/save, bit2 prev/load, bit3 confirm/play.
REQ-013 iSensor  in  NUM_PADS  asynchronous pad hit levels, high = hit.
REQ-014 iPixel  in  24  background BGR pixel, aligned with iBLANK_n.
REQ-015 oPixel  out  24  composed BGR pixel, registered.
REQ-016 oScreen  out  3  current state encoding (REQ-020).
REQ-017 oSlot  out  clog2(NUM_SLOTS)  currently selected slot.
REQ-018 oSave, oLoad  out  1 each  one-cycle commit pulses, qualified by oSlot.

Function
REQ-019 iBtn and iSensor SHALL pass a 2-flop synchroniser; an event is a synchronised 0->1 edge; levels held high generate exactly one event.
REQ-020 FSM states: SPLASH=0, MAIN=1, SAVE=2, LOAD=3, GAME=4; oScreen SHALL equal the state register.
REQ-021 SPLASH -> MAIN on any button event.
REQ-022 MAIN -> SAVE on bit1, LOAD on bit2, GAME on bit3 event; bit0 ignored.
REQ-023 SAVE/LOAD: bit1 increments oSlot (NUM_SLOTS-1 wraps to 0), bit2 decrements (0 wraps to NUM_SLOTS-1), bit3 pulses oSave (SAVE) or oLoad (LOAD) for one cycle and goes to MAIN, bit0 goes to MAIN with no pulse.
REQ-024 GAME -> MAIN on bit0 event; other buttons ignored.
REQ-025 Simultaneous button events in one cycle: lowest bit index wins; all others are discarded.
REQ-026 oSlot SHALL persist across states; a pulse uses the oSlot value present when the pulse is asserted.
REQ-027 Unused state encodings SHALL recover to MAIN on the next cycle.
REQ-028 Pixel counters x, y: x increments each cycle iBLANK_n=1; x==H_ACTIVE-1 wraps to 0 and increments y; y==V_ACTIVE-1 wraps to 0; iVS=0 forces x=y=0 (priority over increment).
REQ-029 Per pad: hit event loads counter with HIT_HOLD; counter decrements by 1 on each iVS 1->0 edge, saturating at 0; hit and decrement in one cycle -> load wins.
REQ-030 Overlay priority, GAME: pixel inside lit pad box -> 24'h90EE90 if counter > HIT_HOLD/2 else 24'h32CD32; SAVE/LOAD: inside box of slot oSlot -> 24'hFFFFFF; else iPixel.
REQ-031 Pad counters SHALL keep running outside GAME; overlay drawn only in GAME.
REQ-032 oPixel SHALL be 24'h0 when iBLANK_n=0; latency iPixel -> oPixel exactly 1 cycle.
REQ-033 Box comparisons SHALL use x/y of the same cycle as iPixel; widths sized to hold H_ACTIVE, V_ACTIVE without overflow.

Reset
REQ-034 iRST_n=0 asynchronously: state SPLASH, oSlot 0, oSave=oLoad=0, oPixel 0, x=y=0, pad counters 0, synchroniser and edge registers 0.
REQ-035 Buttons held high through reset release SHALL NOT generate events.
REQ-036 Reset mid-frame or mid-commit SHALL drop pending pulses; no pulse within 2 cycles after release.

Verification
REQ-037 Reset, pulse iBtn[0] -> oScreen 0->1 after 3 cycles; hold iBtn[0] high 100 cycles -> single transition.
REQ-038 MAIN, bit1 event, bit1 x3 (NUM_SLOTS=3), bit3 -> oSlot 0,1,2,0, then oSave=1 one cycle with oSlot=0, oScreen=1.
REQ-039 LOAD, bit2 from slot 0 -> oSlot=2; bit0 -> MAIN, oLoad never asserted.
REQ-040 GAME, iSensor[1] pulse, 16 frames -> pad 1 box 24'h90EE90 frames 1-8, 24'h32CD32 frames 9-16, iPixel from frame 17.
REQ-041 iBtn=4'b1010 edges same cycle in MAIN -> SAVE (bit1 wins), bit3 discarded.
REQ-042 iBLANK_n low, iPixel=24'hFFFFFF -> oPixel 0; counter x reaches 639 -> next active x=0, y+1; iVS low -> x=y=0.

Source files
------------

// File: rtl/vga_screen_ctrl.sv
// Menu/game screen controller for a VGA pipeline: button-driven screen FSM,
// save/load slot selection, pad hit timers and a one-cycle pixel overlay stage.
module vga_screen_ctrl #(
  parameter int NUM_SLOTS  = 3,
  parameter int NUM_PADS   = 3,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int HIT_HOLD   = 16,
  parameter int PAD_X0     = 155,
  parameter int PAD_PITCH  = 146,
  parameter int PAD_W      = 38,
  parameter int PAD_Y0     = 199,
  parameter int PAD_H      = 48,
  parameter int SLOT_X0    = 12,
  parameter int SLOT_W     = 112,
  parameter int SLOT_Y0    = 287,
  parameter int SLOT_PITCH = 32,
  parameter int SLOT_H     = 28,
  localparam int SW        = $clog2(NUM_SLOTS)
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_n,
  input  logic                iBLANK_n,
  input  logic                iVS,
  input  logic [3:0]          iBtn,
  input  logic [NUM_PADS-1:0] iSensor,
  input  logic [23:0]         iPixel,
  output logic [23:0]         oPixel,
  output logic [2:0]          oScreen,
  output logic [SW-1:0]       oSlot,
  output logic                oSave,
  output logic                oLoad
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int IW = 4 + NUM_PADS;

  typedef enum logic [2:0] {
    SPLASH = 3'd0,
    MAIN   = 3'd1,
    SAVE   = 3'd2,
    LOAD   = 3'd3,
    GAME   = 3'd4
  } state_t;

  state_t              state_q;
  logic [SW-1:0]       slot_q;
  logic                save_q, load_q;
  logic [IW-1:0]       sync1_q, sync2_q, prev_q;
  logic [1:0]          settle_q;
  logic [IW-1:0]       ev;
  logic [3:0]          btn_ev, btn_sel;
  logic [NUM_PADS-1:0] hit_ev;
  logic                vs_prev_q, vs_fall;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [31:0]         x_w, y_w;
  logic [NUM_PADS-1:0] pad_on, pad_bright;
  logic [(1<<SW)-1:0]  in_slot;
  logic [23:0]         pix_d, pix_q;
  logic [SW-1:0]       slot_inc, slot_dec;

  // Edges are ignored until the synchroniser has refilled after reset, so
  // inputs held high through reset release never look like a fresh press.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      settle_q <= 2'd0;
    end else begin
      sync1_q <= {iSensor, iBtn};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  assign ev      = sync2_q & ~prev_q & {IW{settle_q == 2'd3}};
  assign btn_ev  = ev[3:0];
  assign hit_ev  = ev[IW-1:4];
  assign btn_sel = btn_ev & (~btn_ev + 4'd1);

  assign slot_inc = (slot_q == SW'(NUM_SLOTS - 1)) ? '0 : slot_q + SW'(1);
  assign slot_dec = (slot_q == '0) ? SW'(NUM_SLOTS - 1) : slot_q - SW'(1);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= SPLASH;
      slot_q  <= '0;
      save_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      save_q <= 1'b0;
      load_q <= 1'b0;
      case (state_q)
        SPLASH: if (|btn_ev) state_q <= MAIN;
        MAIN: begin
          if (btn_sel[1])      state_q <= SAVE;
          else if (btn_sel[2]) state_q <= LOAD;
          else if (btn_sel[3]) state_q <= GAME;
        end
        SAVE, LOAD: begin
          if (btn_sel[0])      state_q <= MAIN;
          else if (btn_sel[1]) slot_q  <= slot_inc;
          else if (btn_sel[2]) slot_q  <= slot_dec;
          else if (btn_sel[3]) begin
            save_q  <= (state_q == SAVE);
            load_q  <= (state_q == LOAD);
            state_q <= MAIN;
          end
        end
        GAME: if (btn_sel[0]) state_q <= MAIN;
        default: state_q <= MAIN;
      endcase
    end
  end

  // x/y name the pixel currently presented on iPixel.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_q       <= '0;
      y_q       <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_prev_q <= iVS;
      if (!iVS) begin
        x_q <= '0;
        y_q <= '0;
      end else if (iBLANK_n) begin
        if (x_q == XW'(H_ACTIVE - 1)) begin
          x_q <= '0;
          y_q <= (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  assign vs_fall = vs_prev_q & ~iVS;
  assign x_w     = 32'(x_q);
  assign y_w     = 32'(y_q);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      localparam logic [31:0] PX = 32'(PAD_X0 + gi * PAD_PITCH);
      logic [7:0] cnt_q;

      always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)                      cnt_q <= 8'd0;
        else if (hit_ev[gi])              cnt_q <= 8'(HIT_HOLD);
        else if (vs_fall && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
      end

      assign pad_on[gi] = (cnt_q != 8'd0) &&
                          (x_w >= PX) && (x_w < PX + 32'(PAD_W)) &&
                          (y_w >= 32'(PAD_Y0)) && (y_w < 32'(PAD_Y0 + PAD_H));
      assign pad_bright[gi] = (cnt_q > 8'(HIT_HOLD / 2));
    end

    for (gi = 0; gi < (1 << SW); gi++) begin : g_slot
      if (gi < NUM_SLOTS) begin : g_real
        localparam logic [31:0] SY = 32'(SLOT_Y0 + gi * SLOT_PITCH);
        assign in_slot[gi] = (x_w >= 32'(SLOT_X0)) && (x_w < 32'(SLOT_X0 + SLOT_W)) &&
                             (y_w >= SY) && (y_w < SY + 32'(SLOT_H));
      end else begin : g_none
        assign in_slot[gi] = 1'b0;
      end
    end
  endgenerate

  // Descending scan so the lowest-numbered lit pad wins any overlap.
  always_comb begin
    pix_d = iPixel;
    if (state_q == GAME) begin
      for (int p = NUM_PADS - 1; p >= 0; p--) begin
        if (pad_on[p]) pix_d = pad_bright[p] ? 24'h90EE90 : 24'h32CD32;
      end
    end else if ((state_q == SAVE || state_q == LOAD) && in_slot[slot_q]) begin
      pix_d = 24'hFFFFFF;
    end
    if (!iBLANK_n) pix_d = 24'h0;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) pix_q <= 24'h0;
    else         pix_q <= pix_d;
  end

  assign oPixel  = pix_q;
  assign oScreen = state_q;
  assign oSlot   = slot_q;
  assign oSave   = save_q;
  assign oLoad   = load_q;

endmodule
